// File: rtl/stream_tap_pkg.sv
// Shared helpers for the stream_tap slice: sizing of the tap repeat counter.
package stream_tap_pkg;

    // Repeat counter spans 0..rep-1 but is never narrower than one bit.
    function automatic int cnt_width(input int rep);
        return (rep < 2) ? 1 : $clog2(rep);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready buffer with registered occupancy; ready depends only on state.
module stream_fifo2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic                  out_vld,
    input  logic                  out_rdy
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr, rd;

    assign in_rdy  = (cnt_q != 2'd2);
    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = mem_q[rd_ptr_q];
    assign wr      = in_vld & in_rdy;
    assign rd      = out_vld & out_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, wr} - {1'b0, rd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/stream_tap.sv
// Stream splitter: every input goes once to the pass-through port and TAP_REP times to the tap port.
module stream_tap
    import stream_tap_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TAP_REP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] idat,
    input  logic                  ivld,
    output logic                  irdy,
    output logic [DATA_WIDTH-1:0] odat,
    output logic                  ovld,
    input  logic                  ordy,
    output logic [DATA_WIDTH-1:0] tdat,
    output logic                  tvld,
    input  logic                  trdy
);

    localparam int             CNT_W = cnt_width(TAP_REP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TAP_REP - 1);

    logic                  o_in_rdy, t_in_rdy, wr;
    logic [DATA_WIDTH-1:0] t_head;
    logic                  t_head_vld, t_pop;
    logic                  hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  xfer, last;

    assign irdy = ~rst & o_in_rdy & t_in_rdy;
    assign wr   = ivld & irdy;

    stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (idat),
        .in_vld  (wr),
        .in_rdy  (o_in_rdy),
        .out_dat (odat),
        .out_vld (ovld),
        .out_rdy (ordy)
    );

    stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_tap_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_dat  (idat),
        .in_vld  (wr),
        .in_rdy  (t_in_rdy),
        .out_dat (t_head),
        .out_vld (t_head_vld),
        .out_rdy (t_pop)
    );

    // An idle replicator shows the buffer head directly so the first copy costs no extra cycle.
    assign tvld = hold_vld_q | t_head_vld;
    assign tdat = hold_vld_q ? hold_dat_q : t_head;
    assign xfer = tvld & trdy;
    assign last = (cnt_q == LAST);

    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        cnt_d      = cnt_q;
        t_pop      = 1'b0;
        if (hold_vld_q) begin
            if (xfer && last) begin
                cnt_d      = '0;
                t_pop      = t_head_vld;
                hold_vld_d = t_head_vld;
                hold_dat_d = t_head;
            end else if (xfer) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (t_head_vld) begin
            t_pop = 1'b1;
            if (xfer && last) begin
                hold_vld_d = 1'b0;
                cnt_d      = '0;
            end else begin
                hold_vld_d = 1'b1;
                hold_dat_d = t_head;
                cnt_d      = xfer ? CNT_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_dat_q <= hold_dat_d;
    end

endmodule

// File: tb/tb_stream_tap.sv
// Randomized bench for stream_tap: a TAP_REP=7 instance and a TAP_REP=1 instance against a queue model.
module tb_stream_tap;

    localparam int REP7 = 7;
    localparam int NRND = 1357;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [8:0] idat7 = '0, odat7, tdat7;
    logic       ivld7 = 1'b0, irdy7, ovld7, ordy7 = 1'b1, tvld7, trdy7 = 1'b1;
    logic [7:0] idat1 = '0, odat1, tdat1;
    logic       ivld1 = 1'b0, irdy1, ovld1, ordy1 = 1'b1, tvld1, trdy1 = 1'b1;

    logic [8:0] oq7[$], tq7[$];
    logic [7:0] oq1[$], tq1[$];
    int n_out7 = 0, n_tap7 = 0, n_out1 = 0, n_tap1 = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    stream_tap #(.DATA_WIDTH(9), .TAP_REP(REP7)) dut7 (
        .clk(clk), .rst(rst), .idat(idat7), .ivld(ivld7), .irdy(irdy7),
        .odat(odat7), .ovld(ovld7), .ordy(ordy7),
        .tdat(tdat7), .tvld(tvld7), .trdy(trdy7)
    );

    stream_tap #(.DATA_WIDTH(8), .TAP_REP(1)) dut1 (
        .clk(clk), .rst(rst), .idat(idat1), .ivld(ivld1), .irdy(irdy1),
        .odat(odat1), .ovld(ovld1), .ordy(ordy1),
        .tdat(tdat1), .tvld(tvld1), .trdy(trdy1)
    );

    // Model: each accepted item is owed once on odat and REP times on tdat, in order.
    task automatic run_scoreboard();
        logic [8:0] e9;
        logic [7:0] e8;
        forever begin
            @(negedge clk);
            if (rst) begin
                oq7.delete(); tq7.delete(); oq1.delete(); tq1.delete();
            end else begin
                checks++;
                if (ovld7 !== (oq7.size() != 0)) begin
                    errors++; $display("FAIL ovld7_state: got %b want %b", ovld7, oq7.size() != 0);
                end
                checks++;
                if (tvld7 !== (tq7.size() != 0)) begin
                    errors++; $display("FAIL tvld7_state: got %b want %b", tvld7, tq7.size() != 0);
                end
                checks++;
                if (ovld1 !== (oq1.size() != 0)) begin
                    errors++; $display("FAIL ovld1_state: got %b want %b", ovld1, oq1.size() != 0);
                end
                checks++;
                if (tvld1 !== (tq1.size() != 0)) begin
                    errors++; $display("FAIL tvld1_state: got %b want %b", tvld1, tq1.size() != 0);
                end
                if (ovld7 && ordy7) begin
                    e9 = (oq7.size() != 0) ? oq7.pop_front() : 'x;
                    checks++; n_out7++;
                    if (odat7 !== e9) begin
                        errors++; $display("FAIL odat7: got %h want %h", odat7, e9);
                    end
                end
                if (tvld7 && trdy7) begin
                    e9 = (tq7.size() != 0) ? tq7.pop_front() : 'x;
                    checks++; n_tap7++;
                    if (tdat7 !== e9) begin
                        errors++; $display("FAIL tdat7: got %h want %h", tdat7, e9);
                    end
                end
                if (ovld1 && ordy1) begin
                    e8 = (oq1.size() != 0) ? oq1.pop_front() : 'x;
                    checks++; n_out1++;
                    if (odat1 !== e8) begin
                        errors++; $display("FAIL odat1: got %h want %h", odat1, e8);
                    end
                end
                if (tvld1 && trdy1) begin
                    e8 = (tq1.size() != 0) ? tq1.pop_front() : 'x;
                    checks++; n_tap1++;
                    if (tdat1 !== e8) begin
                        errors++; $display("FAIL tdat1: got %h want %h", tdat1, e8);
                    end
                end
                if (ivld7 && irdy7) begin
                    oq7.push_back(idat7);
                    for (int k = 0; k < REP7; k++) tq7.push_back(idat7);
                end
                if (ivld1 && irdy1) begin
                    oq1.push_back(idat1);
                    tq1.push_back(idat1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ovld7, tvld7, irdy7, ovld1, tvld1, irdy1} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b want 000000", {ovld7, tvld7, irdy7, ovld1, tvld1, irdy1});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({irdy7, irdy1} !== 2'b11) begin
            errors++; $display("FAIL irdy_after_reset: got %b want 11", {irdy7, irdy1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [11:0] tpat, opat;
        int base = n_tap7;
        idat7 = 9'h005; ivld7 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ivld7 = 1'b0;
        checks++;
        if ({ovld7, odat7, tvld7, tdat7} !== {1'b1, 9'h005, 1'b1, 9'h005}) begin
            errors++;
            $display("FAIL single_latency: got o=%b/%h t=%b/%h want 1/005 1/005", ovld7, odat7, tvld7, tdat7);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tpat[11-i] = tvld7;
            opat[11-i] = ovld7;
        end
        @(posedge clk); #1;
        checks++;
        if (tpat !== 12'b111111100000) begin
            errors++; $display("FAIL single_tap_pattern: got %b want 111111100000", tpat);
        end
        checks++;
        if (opat !== 12'b100000000000) begin
            errors++; $display("FAIL single_out_pattern: got %b want 100000000000", opat);
        end
        checks++;
        if (n_tap7 - base !== 7) begin
            errors++; $display("FAIL single_tap_count: got %0d want 7", n_tap7 - base);
        end
    endtask

    task automatic test_rep1_stream();
        int bo = n_out1, bt = n_tap1;
        logic acc;
        ivld1 = 1'b1; idat1 = 8'($urandom);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            acc = ivld1 && irdy1;
            checks++;
            if (irdy1 !== 1'b1) begin
                errors++; $display("FAIL rep1_irdy: cycle %0d got %b want 1", c, irdy1);
            end
            if (c > 0) begin
                checks++;
                if (!(ovld1 === 1'b1 && tvld1 === 1'b1 && odat1 === tdat1)) begin
                    errors++;
                    $display("FAIL rep1_lockstep: cycle %0d got o=%b/%h t=%b/%h want both valid and equal", c, ovld1, odat1, tvld1, tdat1);
                end
            end
            @(posedge clk); #1;
            if (acc) idat1 = 8'($urandom);
        end
        ivld1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_out1 - bo !== 50 || n_tap1 - bt !== 50) begin
            errors++; $display("FAIL rep1_counts: got out=%0d tap=%0d want 50 50", n_out1 - bo, n_tap1 - bt);
        end
    endtask

    task automatic test_backpressure();
        int bo = n_out7, bt = n_tap7;
        int acc_n = 0;
        logic a, got;
        ordy7 = 1'b0; trdy7 = 1'b1;
        ivld7 = 1'b1; idat7 = 9'd1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a = ivld7 && irdy7;
            @(posedge clk); #1;
            if (a) begin
                acc_n++;
                idat7 = 9'(acc_n + 1);
            end
        end
        checks++;
        if (acc_n !== 2 || irdy7 !== 1'b0) begin
            errors++; $display("FAIL bp_stall: got accepted=%0d irdy=%b want 2 0", acc_n, irdy7);
        end
        checks++;
        if (n_tap7 - bt !== 14 || n_out7 - bo !== 0) begin
            errors++; $display("FAIL bp_tap_drain: got tap=%0d out=%0d want 14 0", n_tap7 - bt, n_out7 - bo);
        end
        ordy7 = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            a = ivld7 && irdy7;
            @(posedge clk); #1;
            if (a) begin
                got = 1'b1;
                ivld7 = 1'b0;
            end
        end
        ivld7 = 1'b0;
        checks++;
        if (got !== 1'b1) begin
            errors++; $display("FAIL bp_resume: got accepted=%b want 1", got);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_out7 - bo !== 3 || n_tap7 - bt !== 21) begin
            errors++; $display("FAIL bp_final: got out=%0d tap=%0d want 3 21", n_out7 - bo, n_tap7 - bt);
        end
    endtask

    task automatic test_random_stalls();
        int bo = n_out7, bt = n_tap7;
        int idx = 0, cyc = 0;
        logic acc;
        ivld7 = 1'b0;
        while ((idx < NRND || oq7.size() != 0 || tq7.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            acc = ivld7 && irdy7;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (!(ivld7 && !acc)) ivld7 = (idx < NRND) && ($urandom_range(10) != 0);
            idat7 = 9'(idx);
            ordy7 = ($urandom_range(6) != 0);
            trdy7 = ($urandom_range(30) != 0);
        end
        ivld7 = 1'b0; ordy7 = 1'b1; trdy7 = 1'b1;
        checks++;
        if (cyc >= 20000) begin
            errors++; $display("FAIL rnd_timeout: got idx=%0d want %0d within budget", idx, NRND);
        end
        checks++;
        if (n_out7 - bo !== NRND || n_tap7 - bt !== NRND * REP7) begin
            errors++;
            $display("FAIL rnd_counts: got out=%0d tap=%0d want %0d %0d", n_out7 - bo, n_tap7 - bt, NRND, NRND * REP7);
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [8:0]  a_val = 9'($urandom_range(511));
        logic [8:0]  b_val = 9'($urandom_range(511));
        logic [11:0] tpat;
        int bt = n_tap7;
        int nz = 0;
        idat7 = a_val; ivld7 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ivld7 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n_tap7 - bt !== 2 || tvld7 !== 1'b1 || tdat7 !== a_val) begin
            errors++;
            $display("FAIL mid_third_copy: got taps=%0d tvld=%b tdat=%h want 2 1 %h", n_tap7 - bt, tvld7, tdat7, a_val);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tvld7, ovld7, irdy7} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_outputs: got %b want 000", {tvld7, ovld7, irdy7});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tvld7 !== 1'b0 || ovld7 !== 1'b0) nz++;
        end
        @(posedge clk); #1;
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL mid_no_leftover: got %0d valid cycles want 0", nz);
        end
        bt = n_tap7;
        idat7 = b_val; ivld7 = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        ivld7 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tpat[11-i] = tvld7;
        end
        @(posedge clk); #1;
        checks++;
        if (tpat !== 12'b111111100000 || n_tap7 - bt !== 7) begin
            errors++;
            $display("FAIL mid_next_item: got pattern=%b taps=%0d want 111111100000 7", tpat, n_tap7 - bt);
        end
    endtask

    initial begin
        #1;
        fork
            run_scoreboard();
        join_none
        test_reset();
        test_single();
        test_rep1_stream();
        test_backpressure();
        test_random_stalls();
        test_reset_mid_repeat();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
